// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end blocks: default sizes, sample type,
// and the bit-reversal helper used for decimation-in-time lane ordering.
package fft_pkg;

   localparam int FFT_N            = 4;
   localparam int FFT_SAMPLE_WIDTH = 16;

   typedef logic [FFT_SAMPLE_WIDTH-1:0] sample_t;

   function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
      int unsigned r;
      r = 0;
      for (int unsigned b = 0; b < width; b++) begin
         if (idx[b]) r = r | (32'd1 << (width - 1 - b));
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_sample_framer.sv
// Serial-to-frame packer feeding the parallel FFT: N accepted samples become one
// N-lane frame. Define FFT_FRAMER_BITREV_EN to place sample k in lane bitrev(k).
//
// state   | meaning
// --------+----------------------------------------------------------
// FILL_0  | cnt == 0, no samples of the current frame held
// FILL_k  | cnt == k, samples 0..k-1 held in fill[]
// FILL_N-1| next accepted sample completes the frame (needs out_free)
module fft_sample_framer
   import fft_pkg::*;
#(
   parameter int N            = FFT_N,
   parameter int SAMPLE_WIDTH = FFT_SAMPLE_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [SAMPLE_WIDTH-1:0]           s_data,
   input  logic                              s_last,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [N-1:0][SAMPLE_WIDTH-1:0]    m_data,
   output logic                              frame_err
);

   localparam int CNT_WIDTH = $clog2(N);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N - 1);

   logic [CNT_WIDTH-1:0]           cnt;
   logic [CNT_WIDTH-1:0]           cnt_next;
   logic [SAMPLE_WIDTH-1:0]        fill [N-1];
   logic                           at_last;
   logic                           out_free;
   logic                           accept;
   logic                           load;
   logic                           early_last;
   logic [N-1:0][SAMPLE_WIDTH-1:0] frame_next;

   function automatic int unsigned lane_of(input int unsigned k);
`ifdef FFT_FRAMER_BITREV_EN
      return bitrev(k, CNT_WIDTH);
`else
      return k;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_next;
   end

   always_comb begin
      cnt_next = cnt;
      if (accept) begin
         if (at_last || s_last) cnt_next = '0;
         else                   cnt_next = cnt + CNT_WIDTH'(1);
      end
   end

   // s_ready only stalls when the last sample would have nowhere to go
   always_comb begin
      at_last    = (cnt == CNT_LAST);
      out_free   = !m_valid || m_ready;
      s_ready    = !at_last || out_free;
      accept     = s_valid && s_ready;
      load       = accept && at_last;
      early_last = accept && !at_last && s_last;
   end

   always_comb begin
      frame_next = '0;
      for (int k = 0; k < N - 1; k++) begin
         frame_next[CNT_WIDTH'(lane_of(k))] = fill[k];
      end
      frame_next[CNT_WIDTH'(lane_of(N - 1))] = s_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid   <= 1'b0;
         m_data    <= '0;
         frame_err <= 1'b0;
         for (int i = 0; i < N - 1; i++) fill[i] <= '0;
      end else begin
         frame_err <= early_last;
         if (load) begin
            m_data  <= frame_next;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (accept && !at_last && !s_last) begin
            for (int i = 0; i < N - 1; i++) begin
               if (cnt == CNT_WIDTH'(i)) fill[i] <= s_data;
            end
         end
      end
   end

endmodule
